// File: rtl/wm8960_init_ctrl.sv
// WM8960 power-up sequencer: walks the register init table and issues one I2C write per entry.
// Optional NACK retry support is enabled with `define WM8960_INIT_RETRY_EN.
module wm8960_init_ctrl #(
  parameter int ADDR_WIDTH        = 8,
  parameter int DATA_WIDTH        = 16,
  parameter int PWRUP_CYCLES      = 1_000_000,
  parameter int RESET_WAIT_CYCLES = 50_000,
  parameter int MAX_RETRY         = 3,
  parameter int RETRY_GAP_CYCLES  = 5_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_q,
  input  logic [7:0]            lut_dev_id,
  input  logic [7:0]            lut_size,
  output logic                  i2c_go,
  output logic [7:0]            i2c_dev,
  output logic [7:0]            i2c_byte_hi,
  output logic [7:0]            i2c_byte_lo,
  input  logic                  i2c_busy,
  input  logic                  i2c_done,
  input  logic                  i2c_nack,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_WIDTH-1:0] err_index
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [31:0] PWRUP_LAST  = 32'(PWRUP_CYCLES - 1);
  localparam logic [31:0] RESET_LAST  = 32'(RESET_WAIT_CYCLES - 1);
  localparam logic [6:0]  SOFT_RESET_REG = 7'h0F;
`ifdef WM8960_INIT_RETRY_EN
  localparam logic [31:0] GAP_LAST    = 32'(RETRY_GAP_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIM   = 8'(MAX_RETRY);
`endif

  state_t                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   err_index_q, err_index_d;
  logic                    go_q, go_d;
  logic [7:0]              dev_q, dev_d;
  logic [7:0]              hi_q, hi_d;
  logic [7:0]              lo_q, lo_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
`ifdef WM8960_INIT_RETRY_EN
  logic [7:0]              attempt_q, attempt_d;
  logic                    gap_q, gap_d;
`endif

  logic [ADDR_WIDTH-1:0]   last_idx;
  logic [31:0]             settle_last;
  logic                    advance;
  logic                    fail;

  always_comb begin
    last_idx = ADDR_WIDTH'(lut_size - 8'd1);
`ifdef WM8960_INIT_RETRY_EN
    settle_last = gap_q ? GAP_LAST : RESET_LAST;
`else
    settle_last = RESET_LAST;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_index_d = err_index_q;
    go_d        = 1'b0;
    dev_d       = dev_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    advance     = 1'b0;
    fail        = 1'b0;
`ifdef WM8960_INIT_RETRY_EN
    attempt_d   = attempt_q;
    gap_d       = gap_q;
`endif

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          if (lut_size == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_FETCH: state_d = S_LATCH;

      S_LATCH: begin
        dev_d   = lut_dev_id;
        hi_d    = lut_q[15:8];
        lo_d    = lut_q[7:0];
`ifdef WM8960_INIT_RETRY_EN
        attempt_d = '0;
`endif
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (!i2c_busy) begin
          go_d    = 1'b1;
          state_d = S_WAIT;
        end
      end

      // The register field is taken from the latched high byte; it equals
      // lut_q[15:9] because lut_addr does not move while an entry is in flight.
      S_WAIT: begin
        if (i2c_done) begin
          if (!i2c_nack) begin
            if (hi_q[7:1] == SOFT_RESET_REG) begin
              state_d = S_SETTLE;
              cnt_d   = '0;
`ifdef WM8960_INIT_RETRY_EN
              gap_d   = 1'b0;
`endif
            end else begin
              advance = 1'b1;
            end
          end else begin
`ifdef WM8960_INIT_RETRY_EN
            if (attempt_q < RETRY_LIM) begin
              attempt_d = attempt_q + 8'd1;
              gap_d     = 1'b1;
              cnt_d     = '0;
              state_d   = S_SETTLE;
            end else begin
              fail = 1'b1;
            end
`else
            fail = 1'b1;
`endif
          end
        end
      end

      S_SETTLE: begin
        if (cnt_q == settle_last) begin
          cnt_d = '0;
`ifdef WM8960_INIT_RETRY_EN
          if (gap_q) state_d = S_ISSUE;
          else       advance = 1'b1;
`else
          advance = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_DONE, S_ERROR: begin
        if (start) begin
          idx_d  = '0;
          err_d  = 1'b0;
          if (lut_size == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end

      default: state_d = S_PWRUP;
    endcase

    if (advance) begin
      if (idx_q == last_idx) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    if (fail) begin
      state_d     = S_ERROR;
      busy_d      = 1'b0;
      err_d       = 1'b1;
      err_index_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      err_index_q <= '0;
      go_q        <= 1'b0;
      dev_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef WM8960_INIT_RETRY_EN
      attempt_q   <= '0;
      gap_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_index_q <= err_index_d;
      go_q        <= go_d;
      dev_q       <= dev_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef WM8960_INIT_RETRY_EN
      attempt_q   <= attempt_d;
      gap_q       <= gap_d;
`endif
    end
  end

  assign lut_addr    = idx_q;
  assign i2c_go      = go_q;
  assign i2c_dev     = dev_q;
  assign i2c_byte_hi = hi_q;
  assign i2c_byte_lo = lo_q;
  assign init_busy   = busy_q;
  assign init_done   = done_q;
  assign init_err    = err_q;
  assign err_index   = err_index_q;

endmodule

// File: tb/tb_wm8960_init_ctrl.sv
// Bench for wm8960_init_ctrl: I2C engine model plus a transaction-list reference model.
`timescale 1ns/1ps
module tb_wm8960_init_ctrl;

  localparam int PWRUP   = 10;
  localparam int RWAIT   = 20;
  localparam int MAXR    = 2;
  localparam int GAP     = 5;
  localparam int N       = 16;
  localparam int I2C_LAT = 8;
`ifdef WM8960_INIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  lut_addr;
  logic [15:0] lut_q;
  logic [7:0]  lut_dev_id, lut_size;
  logic        i2c_go;
  logic [7:0]  i2c_dev, i2c_byte_hi, i2c_byte_lo;
  logic        i2c_busy, i2c_done, i2c_nack;
  logic        init_busy, init_done, init_err;
  logic [7:0]  err_index;
  logic        eng_busy, hold_busy;

  assign i2c_busy = eng_busy | hold_busy;

  wm8960_init_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .PWRUP_CYCLES(PWRUP),
    .RESET_WAIT_CYCLES(RWAIT), .MAX_RETRY(MAXR), .RETRY_GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .lut_addr(lut_addr), .lut_q(lut_q), .lut_dev_id(lut_dev_id), .lut_size(lut_size),
    .i2c_go(i2c_go), .i2c_dev(i2c_dev), .i2c_byte_hi(i2c_byte_hi), .i2c_byte_lo(i2c_byte_lo),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .init_busy(init_busy), .init_done(init_done), .init_err(init_err), .err_index(err_index)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       nack;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  logic [15:0] tbl[N];
  int unsigned nack_plan[N];
  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned cyc, go_count, first_go_cyc, last_done_cyc, exp_total, exp_err_idx;
  int unsigned eng_cnt;
  bit          exp_err, gap_valid, last_done_nack, prev_go;
  logic [6:0]  last_done_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: list every write the sequence must issue and the final outcome.
  function automatic void build_expected();
    int unsigned allowed;
    txn_t t;
    allowed = RETRY_EN ? MAXR + 1 : 1;
    exp_q.delete();
    exp_err = 1'b0;
    exp_err_idx = 0;
    for (int e = 0; e < N; e++) begin
      t.dev = 8'h34;
      t.hi  = tbl[e][15:8];
      t.lo  = tbl[e][7:0];
      if (nack_plan[e] >= allowed) begin
        t.nack = 1'b1;
        for (int unsigned a = 0; a < allowed; a++) exp_q.push_back(t);
        exp_err = 1'b1;
        exp_err_idx = e;
        break;
      end
      t.nack = 1'b1;
      for (int unsigned a = 0; a < nack_plan[e]; a++) exp_q.push_back(t);
      t.nack = 1'b0;
      exp_q.push_back(t);
    end
    exp_total = exp_q.size();
    go_count  = 0;
    gap_valid = 1'b0;
  endfunction

  // I2C engine model and ROM, both driven on the falling edge.
  initial begin
    eng_busy = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
    prev_go = 1'b0; cyc = 0; eng_cnt = 0; lut_q = '0;
    forever begin
      @(negedge clk);
      cyc++;
      lut_q = (lut_addr < N) ? tbl[lut_addr[3:0]] : 16'hDEAD;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (reset) begin
        eng_busy = 1'b0;
        prev_go  = 1'b0;
      end else begin
        if (i2c_go) begin
          check("go_while_busy", 32'(i2c_busy), 0);
          check("go_back_to_back", 32'(prev_go), 0);
          go_count++;
          if (go_count == 1) first_go_cyc = cyc;
          if (gap_valid && last_done_nack)
            check("retry_gap_ok", 32'((cyc - last_done_cyc) >= GAP), 1);
          else if (gap_valid && last_done_reg == 7'h0F)
            check("settle_gap_ok", 32'((cyc - last_done_cyc) >= RWAIT), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_go", go_count, exp_total);
          end else begin
            cur = exp_q.pop_front();
            check("go_dev", 32'(i2c_dev), 32'(cur.dev));
            check("go_hi", 32'(i2c_byte_hi), 32'(cur.hi));
            check("go_lo", 32'(i2c_byte_lo), 32'(cur.lo));
            eng_busy = 1'b1;
            eng_cnt  = I2C_LAT;
          end
        end else if (eng_busy) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            check("hold_hi", 32'(i2c_byte_hi), 32'(cur.hi));
            check("hold_lo", 32'(i2c_byte_lo), 32'(cur.lo));
            i2c_done       = 1'b1;
            i2c_nack       = cur.nack;
            eng_busy       = 1'b0;
            last_done_cyc  = cyc;
            last_done_nack = cur.nack;
            last_done_reg  = cur.hi[7:1];
            gap_valid      = 1'b1;
          end
        end
        prev_go = i2c_go;
      end
    end
  end

  task automatic check_reset_vals(input string p);
    check({p, "_lut_addr"}, 32'(lut_addr), 0);
    check({p, "_go"}, 32'(i2c_go), 0);
    check({p, "_dev"}, 32'(i2c_dev), 0);
    check({p, "_hi"}, 32'(i2c_byte_hi), 0);
    check({p, "_lo"}, 32'(i2c_byte_lo), 0);
    check({p, "_busy"}, 32'(init_busy), 1);
    check({p, "_done"}, 32'(init_done), 0);
    check({p, "_err"}, 32'(init_err), 0);
    check({p, "_err_index"}, 32'(err_index), 0);
  endtask

  task automatic wait_go(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (go_count < target && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_go_seen"}, 32'(go_count >= target), 1);
  endtask

  task automatic wait_end(input string tag);
    int unsigned n = 0;
    while (!(init_done || init_err) && n < 3000) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_finished"}, 32'(init_done || init_err), 1);
    check({tag, "_done"}, 32'(init_done), 32'(!exp_err));
    check({tag, "_err"}, 32'(init_err), 32'(exp_err));
    check({tag, "_busy"}, 32'(init_busy), 0);
    check({tag, "_go_count"}, go_count, exp_total);
    check({tag, "_pending"}, exp_q.size(), 0);
    if (exp_err) check({tag, "_err_index"}, 32'(err_index), exp_err_idx);
  endtask

  task automatic pulse_start(output int unsigned at);
    tick();
    start = 1'b1;
    at = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_plan();
    for (int e = 0; e < N; e++) nack_plan[e] = 0;
  endtask

  initial begin
    int unsigned rel, st, gc, n;
    reset = 1'b1; start = 1'b0; hold_busy = 1'b0;
    lut_dev_id = 8'h34; lut_size = 8'(N);
    tbl = '{ {7'h0F, 9'h000}, {7'h19, 9'h0FC}, {7'h1A, 9'h1F8}, {7'h2F, 9'h00C},
             {7'h04, 9'h000}, {7'h05, 9'h000}, {7'h07, 9'h002}, {7'h02, 9'h179},
             {7'h03, 9'h179}, {7'h00, 9'h117}, {7'h01, 9'h117}, {7'h22, 9'h100},
             {7'h25, 9'h100}, {7'h2D, 9'h080}, {7'h2E, 9'h080}, {7'h08, 9'h1C4} };
    clear_plan();
    repeat (3) tick();
    check_reset_vals("por");

    // Nominal run from power-up.
    build_expected();
    reset = 1'b0;
    rel = cyc;
    wait_go(1, "nom_first");
    check("pwrup_latency_ok", 32'((first_go_cyc - rel) >= PWRUP + 2), 1);
    wait_end("nominal");
    check("nominal_gos", go_count, N);

    // Restart from DONE with NACKs on entry 5; a mid-run start must be ignored.
    nack_plan[5] = 2;
    build_expected();
    pulse_start(st);
    check("restart_addr", 32'(lut_addr), 0);
    check("restart_busy", 32'(init_busy), 1);
    check("restart_done_clr", 32'(init_done), 0);
    wait_go(1, "restart");
    check("no_pwrup_wait", 32'((first_go_cyc - st) < PWRUP), 1);
    wait_go(4, "mid");
    pulse_start(st);
    wait_end("retry");

    // Entry 9 never ACKs.
    clear_plan();
    nack_plan[9] = 100;
    build_expected();
    pulse_start(st);
    wait_end("exhaust");
    check("exhaust_err_index", 32'(err_index), 9);
    gc = go_count;
    repeat (50) tick();
    check("no_go_after_err", go_count, gc);

    // Busy held across ISSUE.
    clear_plan();
    build_expected();
    pulse_start(st);
    wait_go(3, "busy_pre");
    n = 0;
    while (!i2c_done && n < 100) begin
      tick();
      n++;
    end
    check("busy_done_seen", 32'(i2c_done), 1);
    hold_busy = 1'b1;
    gc = go_count;
    repeat (30) tick();
    check("busy_hold_no_go", go_count, gc);
    check("busy_hold_running", 32'(init_busy), 1);
    hold_busy = 1'b0;
    wait_go(gc + 1, "busy_release");

    // Reset while waiting on the engine.
    wait_go(6, "rst_pre");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("rst");
    build_expected();
    tick();
    reset = 1'b0;
    rel = cyc;
    wait_go(1, "rst_first");
    check("rst_pwrup_latency_ok", 32'((first_go_cyc - rel) >= PWRUP + 2), 1);
    wait_end("after_reset");

    // Randomised payloads and NACK patterns.
    for (int r = 0; r < 5; r++) begin
      for (int e = 2; e < N; e++)
        if (e != 5 && e != 9) tbl[e][8:0] = 9'($urandom_range(0, 511));
      clear_plan();
      for (int e = 0; e < N; e++)
        if ($urandom_range(0, 5) == 0) nack_plan[e] = $urandom_range(1, 3);
      build_expected();
      pulse_start(st);
      wait_end("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wm8960_init_ctrl.md
# wm8960_init_ctrl

Sequencer that programs the WM8960 codec after power-up by walking the 16-entry register initialisation table and issuing one two-byte I2C write per entry. It sits between the init table ROM and the I2C write engine. It applies a power-up delay, a settle delay after the codec soft-reset write, and bounded NACK retries, then reports done or error to the audio datapath.

## Interface
- `ADDR_WIDTH`, 8: table address width.
- `DATA_WIDTH`, 16: table word width, formatted {reg[6:0], data[8:0]}.
- `PWRUP_CYCLES`, 1_000_000: clocks to wait after reset before the first write (20 ms at 50 MHz).
- `RESET_WAIT_CYCLES`, 50_000: clocks to wait after the soft-reset write (reg 7'h0F) is ACKed.
- `MAX_RETRY`, 3: extra attempts per entry on NACK.
- `RETRY_GAP_CYCLES`, 5_000: idle clocks between a NACK and its retry.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; restarts the sequence from entry 0. Honoured only in DONE or ERROR.
- `lut_addr` out ADDR_WIDTH: table address, registered.
- `lut_q` in DATA_WIDTH: table word, valid one clock after `lut_addr` changes.
- `lut_dev_id` in 8: 8-bit I2C write address (8'h34).
- `lut_size` in 8: number of entries (16).
- `i2c_go` out 1: one-cycle write request.
- `i2c_dev` out 8, `i2c_byte_hi` out 8, `i2c_byte_lo` out 8: held stable from `i2c_go` until `i2c_done`.
- `i2c_busy` in 1: engine busy.
- `i2c_done` in 1: one-cycle completion pulse.
- `i2c_nack` in 1: sampled only with `i2c_done`; 1 means the slave did not ACK.
- `init_busy` out 1: sequence in progress.
- `init_done` out 1: level; all entries written.
- `init_err` out 1: level; retries exhausted.
- `err_index` out ADDR_WIDTH: index of the failed entry.

## Operation
- States: PWRUP, FETCH, LATCH, ISSUE, WAIT, SETTLE, DONE, ERROR.
- PWRUP: count `PWRUP_CYCLES`, then go to FETCH with index 0. If `lut_size`==0, go to DONE instead.
- FETCH: drive `lut_addr`=index for one cycle.
- LATCH: capture `i2c_dev`=`lut_dev_id`, `i2c_byte_hi`=`lut_q[15:8]`, `i2c_byte_lo`=`lut_q[7:0]`. Clear attempt counter on first attempt only.
- ISSUE: wait for `i2c_busy`=0, then pulse `i2c_go` for one cycle and enter WAIT.
- WAIT, on `i2c_done`:
  - ACK, `lut_q[15:9]`==7'h0F: enter SETTLE with `RESET_WAIT_CYCLES`.
  - ACK, other register: advance index. Go to FETCH, or to DONE if the index was `lut_size`-1.
  - NACK: see Configuration.
- SETTLE: count the loaded delay, then advance the index (after a reset write) or reissue the same entry (after a retry gap) via ISSUE.
- DONE: `init_done`=1.
- ERROR: `init_err`=1, `err_index` holds the failing index.
- `start` in DONE/ERROR clears flags and jumps to FETCH with index 0 (no power-up wait). `start` in any other state is ignored.
- Index is 8-bit and never wraps: the last entry is `lut_size`-1.
- `i2c_done` received outside WAIT is ignored.

## Timing
- Reset values: `lut_addr`=0, `i2c_go`=0, `i2c_dev`/`i2c_byte_hi`/`i2c_byte_lo`=0, `init_busy`=1, `init_done`=0, `init_err`=0, `err_index`=0. State is PWRUP with the counter cleared.
- `reset` asserted mid-sequence aborts on the next edge. The I2C engine shares `reset`.
- Table to bus: FETCH (1 clk) then LATCH (1 clk). `i2c_go` fires at the earliest in the 3rd clock after the index update.
- `i2c_go` is never asserted while `i2c_busy`=1 or in consecutive cycles.
- `init_busy` is 0 only in DONE or ERROR.
- Counters compare against the parameter value minus one, so the delay is exactly N clocks.

## Configuration
- `WM8960_INIT_RETRY_EN` defined: a NACK with attempts < `MAX_RETRY` increments the attempt counter and enters SETTLE with `RETRY_GAP_CYCLES`, then reissues the same entry. A NACK with attempts == `MAX_RETRY` goes to ERROR.
- Not defined: the first NACK goes straight to ERROR, and the retry counter logic is removed.

## Test plan
Bench parameters: `PWRUP_CYCLES`=10, `RESET_WAIT_CYCLES`=20, `MAX_RETRY`=2, `RETRY_GAP_CYCLES`=5; the I2C model ACKs after 8 clocks.
- Nominal: release reset, table of 16 entries. Expect 16 `i2c_go` pulses. First pulse has bytes 8'h1E/8'h00 and comes no earlier than clock 12. `init_done`=1, `init_busy`=0.
- Soft-reset settle: measure the gap between `i2c_done` of entry 0 and `i2c_go` of entry 1. Expect ≥ 20 clocks. Entry 1 bytes are 8'h32/8'hFC.
- Retry (macro on): NACK entry 5 twice, then ACK. Expect 3 `i2c_go` pulses with bytes 8'h0A/8'h00, each gap ≥ 5 clocks, and final `init_done`=1.
- Exhausted/no macro: NACK entry 9 always. With the macro, expect 3 attempts; without it, 1 attempt. Then `init_err`=1, `err_index`=9, and no further `i2c_go`.
- Busy/reset: hold `i2c_busy`=1 for 30 clocks at ISSUE and expect no `i2c_go`. Assert `reset` in WAIT and expect all outputs at reset values on the next clock and a fresh power-up count.
- Restart: pulse `start` in DONE. Expect the sequence to restart at `lut_addr`=0 with no power-up delay. Pulse `start` mid-sequence and expect it ignored.
